// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer controller slice.
// Provides the width helpers used to size pointers and to reject illegal
// depth/address-width combinations at elaboration time.
package fifo_pkg;

    localparam int MIN_DEPTH = 2;

    // Number of address bits needed to index 'value' entries.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Pointers carry one extra bit above the address: the wrap bit.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // A depth is legal when it holds at least two entries and every address
    // 0..depth-1 is representable in addr_w bits.
    function automatic bit depth_fits(input int depth, input int addr_w);
        return (depth >= MIN_DEPTH) && (clog2(depth) <= addr_w);
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Bundle between the FIFO's producer/consumer side and the pointer controller.
//   master : requester side (drives flush, wr_req, rd_req; observes the rest)
//   slave  : controller side (fifo_ptr_ctrl)
//
// Handshake: a request (wr_req / rd_req) is a valid that may be held or
// dropped freely; the matching accept (wr_en / rd_en) is a same-cycle ready
// that is combinational from the request and registered state. A transfer
// happens in exactly the cycles where request and accept are both high. A
// request seen without its accept is an error and sets the sticky
// overflow/underflow flag; flush and reset cycles accept and flag nothing.
interface fifo_ptr_ctrl_if #(
    parameter int ADDR_W = 2
);
    logic              flush;
    logic              wr_req;
    logic              rd_req;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   w_ptr;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr_req, rd_req,
        input  wr_en, rd_en, w_addr, r_addr, w_ptr, r_ptr, count,
               full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, wr_req, rd_req,
        output wr_en, rd_en, w_addr, r_addr, w_ptr, r_ptr, count,
               full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_wrap_counter.sv
// Wrap-bit pointer counter for an arbitrary-depth FIFO.
// The low ADDR_W bits count 0..DEPTH-1 and return to 0; the MSB toggles on
// every return so that equal addresses can be told apart as full or empty.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (pointer to 0)
//   clr  synchronous clear, same effect as rst
//   inc  advance the pointer by one entry at this edge
//   ptr  {wrap, addr}
module fifo_wrap_counter
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [ADDR_W:0] ptr
);

    if (!depth_fits(DEPTH, ADDR_W)) begin : g_bad_depth
        $error("fifo_wrap_counter: DEPTH does not fit in ADDR_W bits");
    end

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr[ADDR_W-1:0] == LAST_ADDR) begin
                ptr <= {~ptr[ADDR_W], {ADDR_W{1'b0}}};
            end else begin
                // Address stays below DEPTH-1 here, so no carry reaches the wrap bit.
                ptr <= {ptr[ADDR_W], ptr[ADDR_W-1:0] + 1'b1};
            end
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller for a dual-port storage array.
// Accepts producer writes and consumer reads in the request cycle, supplies
// the memory addresses for those accesses, and keeps occupancy, threshold
// flags and sticky error flags. Any depth up to 2**FIFO_ADDRESS_SIZE works.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; wins over flush and requests
//   bus  fifo_ptr_ctrl_if slave: flush/wr_req/rd_req in; accepts,
//        addresses, pointers, count and flags out
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int MEMORY_DEPTH      = 4,
    parameter int FIFO_ADDRESS_SIZE = 2,
    parameter int AF_LEVEL          = 3,
    parameter int AE_LEVEL          = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_ptr_ctrl_if.slave bus
);

    localparam int PTR_W = ptr_width(FIFO_ADDRESS_SIZE);
    localparam int AW    = FIFO_ADDRESS_SIZE;

    if (!depth_fits(MEMORY_DEPTH, FIFO_ADDRESS_SIZE)) begin : g_bad_depth
        $error("fifo_ptr_ctrl: MEMORY_DEPTH does not fit in FIFO_ADDRESS_SIZE bits");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > MEMORY_DEPTH) begin : g_bad_af
        $error("fifo_ptr_ctrl: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= MEMORY_DEPTH) begin : g_bad_ae
        $error("fifo_ptr_ctrl: AE_LEVEL out of range");
    end

    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(MEMORY_DEPTH);
    localparam logic [PTR_W-1:0] AF_CNT    = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_CNT    = PTR_W'(AE_LEVEL);

    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] count;
    logic             wr_en;
    logic             rd_en;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    // Equal pointers mean empty; equal addresses on opposite laps mean full.
    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[AW-1:0] == r_ptr[AW-1:0]) && (w_ptr[AW] != r_ptr[AW]);

    // A read frees a slot in the same cycle, so a full FIFO still takes a
    // write when it is also being read. No read-bypass when empty.
    assign rd_en = bus.rd_req && !empty && !bus.flush && !rst;
    assign wr_en = bus.wr_req && (!full || rd_en) && !bus.flush && !rst;

    fifo_wrap_counter #(
        .DEPTH  (MEMORY_DEPTH),
        .ADDR_W (AW)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .inc (wr_en),
        .ptr (w_ptr)
    );

    fifo_wrap_counter #(
        .DEPTH  (MEMORY_DEPTH),
        .ADDR_W (AW)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .inc (rd_en),
        .ptr (r_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            count <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Rejected requests are recorded until cleared; reset/flush cycles
    // force the accepts low, which must not count as rejections.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.wr_req && !wr_en) overflow  <= 1'b1;
            if (bus.rd_req && !rd_en) underflow <= 1'b1;
        end
    end

    assign bus.wr_en        = wr_en;
    assign bus.rd_en        = rd_en;
    assign bus.w_addr       = w_ptr[AW-1:0];
    assign bus.r_addr       = r_ptr[AW-1:0];
    assign bus.w_ptr        = w_ptr;
    assign bus.r_ptr        = r_ptr;
    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AF_CNT);
    assign bus.almost_empty = (count <= AE_CNT);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

    // Occupancy bookkeeping must agree with the pointer comparison.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (full == (count == DEPTH_CNT))
                else $error("fifo_ptr_ctrl: full flag disagrees with count");
            assert (empty == (count == '0))
                else $error("fifo_ptr_ctrl: empty flag disagrees with count");
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: directed scenarios plus random traffic on a
// depth-5 instance and a depth-4 instance, checked against an occupancy
// model built from write/read totals and a queue of written addresses.
module tb_fifo_ptr_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    fifo_ptr_ctrl_if #(.ADDR_W(3)) ifa ();
    fifo_ptr_ctrl_if #(.ADDR_W(2)) ifb ();

    fifo_ptr_ctrl #(
        .MEMORY_DEPTH(5), .FIFO_ADDRESS_SIZE(3), .AF_LEVEL(4), .AE_LEVEL(1)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    fifo_ptr_ctrl #(
        .MEMORY_DEPTH(4), .FIFO_ADDRESS_SIZE(2), .AF_LEVEL(3), .AE_LEVEL(1)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    int depth_of [2] = '{5, 4};
    int asz_of   [2] = '{3, 2};
    int af_of    [2] = '{4, 3};
    int ae_of    [2] = '{1, 1};

    int m_wr  [2];
    int m_rd  [2];
    bit m_ovf [2];
    bit m_udf [2];
    int wraps_b;

    logic [3:0] exp_q_a[$];
    logic [3:0] exp_q_b[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_ptr(input int total, input int d);
        int lap;
        lap = (total / depth_of[d]) % 2;
        return 4'((lap << asz_of[d]) + (total % depth_of[d]));
    endfunction

    task automatic model_clear(input int d);
        m_wr[d]  = 0;
        m_rd[d]  = 0;
        m_ovf[d] = 1'b0;
        m_udf[d] = 1'b0;
        if (d == 0) exp_q_a.delete();
        else        exp_q_b.delete();
    endtask

    // ---------------- driver ----------------
    // One clock cycle on instance d: drive at the falling edge, check just
    // after, let the rising edge happen, update the model, return at the
    // next falling edge.
    task automatic step(input int d, input bit wr, input bit rd, input bit fl, input bit rs);
        logic       o_wr_en, o_rd_en, o_full, o_empty, o_af, o_ae, o_ovf, o_udf;
        logic [3:0] o_wa, o_ra, o_wp, o_rp, o_cnt, head;
        int         cnt;
        bit         e_full, e_empty, e_wr_en, e_rd_en;

        if (d == 0) begin
            ifa.wr_req = wr; ifa.rd_req = rd; ifa.flush = fl; rst_a = rs;
        end else begin
            ifb.wr_req = wr; ifb.rd_req = rd; ifb.flush = fl; rst_b = rs;
        end
        #1;
        if (d == 0) begin
            o_wr_en = ifa.wr_en; o_rd_en = ifa.rd_en; o_full = ifa.full; o_empty = ifa.empty;
            o_af = ifa.almost_full; o_ae = ifa.almost_empty; o_ovf = ifa.overflow; o_udf = ifa.underflow;
            o_wa = {1'b0, ifa.w_addr}; o_ra = {1'b0, ifa.r_addr};
            o_wp = ifa.w_ptr; o_rp = ifa.r_ptr; o_cnt = ifa.count;
        end else begin
            o_wr_en = ifb.wr_en; o_rd_en = ifb.rd_en; o_full = ifb.full; o_empty = ifb.empty;
            o_af = ifb.almost_full; o_ae = ifb.almost_empty; o_ovf = ifb.overflow; o_udf = ifb.underflow;
            o_wa = {2'b00, ifb.w_addr}; o_ra = {2'b00, ifb.r_addr};
            o_wp = {1'b0, ifb.w_ptr}; o_rp = {1'b0, ifb.r_ptr}; o_cnt = {1'b0, ifb.count};
        end

        cnt     = m_wr[d] - m_rd[d];
        e_empty = (cnt == 0);
        e_full  = (cnt == depth_of[d]);
        e_rd_en = rd && !e_empty && !fl && !rs;
        e_wr_en = wr && (!e_full || e_rd_en) && !fl && !rs;

        check("wr_en", o_wr_en, e_wr_en);
        check("rd_en", o_rd_en, e_rd_en);
        check("count", o_cnt, cnt);
        check("full", o_full, e_full);
        check("empty", o_empty, e_empty);
        check("almost_full", o_af, cnt >= af_of[d]);
        check("almost_empty", o_ae, cnt <= ae_of[d]);
        check("overflow", o_ovf, m_ovf[d]);
        check("underflow", o_udf, m_udf[d]);
        check("w_ptr", o_wp, exp_ptr(m_wr[d], d));
        check("r_ptr", o_rp, exp_ptr(m_rd[d], d));
        check("w_addr", o_wa, m_wr[d] % depth_of[d]);
        check("r_addr", o_ra, m_rd[d] % depth_of[d]);
        check("full_and_empty", o_full & o_empty, 0);
        if (e_rd_en) begin
            head = (d == 0) ? exp_q_a[0] : exp_q_b[0];
            check("rd_head", o_ra, head);
        end

        @(posedge clk);
        if (rs || fl) begin
            model_clear(d);
        end else begin
            if (wr && !e_wr_en) m_ovf[d] = 1'b1;
            if (rd && !e_rd_en) m_udf[d] = 1'b1;
            if (e_rd_en) begin
                if (d == 0) void'(exp_q_a.pop_front());
                else        void'(exp_q_b.pop_front());
                m_rd[d]++;
            end
            if (e_wr_en) begin
                if (d == 0) exp_q_a.push_back(4'(m_wr[d] % depth_of[d]));
                else        exp_q_b.push_back(4'(m_wr[d] % depth_of[d]));
                if (d == 1 && (m_wr[d] % depth_of[d]) == depth_of[d] - 1) wraps_b++;
                m_wr[d]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ifa.wr_req = 1'b0; ifa.rd_req = 1'b0; ifa.flush = 1'b0;
        ifb.wr_req = 1'b0; ifb.rd_req = 1'b0; ifb.flush = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        model_clear(0);
        model_clear(1);
        wraps_b = 0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset state and five writes up to full.
        #1;
        check("rst_empty", ifa.empty, 1'b1);
        check("rst_almost_empty", ifa.almost_empty, 1'b1);
        check("rst_full", ifa.full, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("t1_w_ptr", ifa.w_ptr, 4'b1000);
        check("t1_count", ifa.count, 4'd5);
        check("t1_full", ifa.full, 1'b1);

        // One read from full, refill, pointers on the second lap.
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("t2_w_ptr", ifa.w_ptr, 4'b1001);
        check("t2_r_ptr", ifa.r_ptr, 4'b0001);
        check("t2_full", ifa.full, 1'b1);

        // Full with simultaneous read and write: pass-through.
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("t3_count", ifa.count, 4'd5);
        check("t3_overflow", ifa.overflow, 1'b0);

        // Empty with simultaneous read and write: only the write goes.
        step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("t4_count", ifa.count, 4'd1);
        check("t4_underflow", ifa.underflow, 1'b1);
        check("t4_almost_empty", ifa.almost_empty, 1'b1);

        // Sticky overflow and underflow, then flush.
        step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(0, 10);
        #1;
        check("t5_overflow_sticky", ifa.overflow, 1'b1);
        check("t5_w_ptr_held", ifa.w_ptr, 4'b1000);
        for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(0, 10);
        #1;
        check("t5_underflow_sticky", ifa.underflow, 1'b1);
        check("t5_r_ptr_held", ifa.r_ptr, 4'b1000);
        step(0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("t5_flush_overflow", ifa.overflow, 1'b0);
        check("t5_flush_underflow", ifa.underflow, 1'b0);
        check("t5_flush_count", ifa.count, 4'd0);
        check("t5_flush_empty", ifa.empty, 1'b1);

        // Random traffic on the depth-5 instance.
        for (int i = 0; i < 400; i++) begin
            step(0, $urandom_range(0, 99) < (((i / 40) % 2) ? 35 : 70),
                    $urandom_range(0, 99) < (((i / 40) % 2) ? 70 : 35),
                    $urandom_range(0, 99) < 2, 1'b0);
        end

        // Random traffic on the depth-4 instance until 20 write wraps,
        // with a reset dropped into a write burst.
        for (int i = 0; i < 4000 && wraps_b < 20; i++) begin
            if (i == 150) begin
                step(1, 1'b1, 1'b1, 1'b0, 1'b1);
            end else begin
                step(1, $urandom_range(0, 99) < (((i / 30) % 2) ? 40 : 75),
                        $urandom_range(0, 99) < (((i / 30) % 2) ? 75 : 40),
                        1'b0, 1'b0);
            end
        end
        check("b_wraps_reached", wraps_b >= 20, 1'b1);
        step(1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check("b_rst_count", ifb.count, 3'd0);
        check("b_rst_w_ptr", ifb.w_ptr, 3'd0);
        check("b_rst_empty", ifb.empty, 1'b1);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Single-clock FIFO pointer controller that generates write and read addresses, occupancy and status flags for a dual-port FIFO memory. It generalises the plain write-address counter in four ways:
- supports any depth, including non-power-of-two, by using wrap-bit pointers
- handles the read side as well as the write side
- adds programmable almost-full and almost-empty thresholds
- adds sticky overflow/underflow detection and a synchronous flush.
It sits between the FIFO's producer/consumer handshakes and the storage array.

Parameters:
MEMORY_DEPTH, 4, number of storage entries; 2 <= MEMORY_DEPTH <= 2**FIFO_ADDRESS_SIZE
FIFO_ADDRESS_SIZE, 2, address width in bits; pointers are FIFO_ADDRESS_SIZE+1 bits wide (MSB = wrap bit)
AF_LEVEL, 3, almost_full asserts when count >= AF_LEVEL; 1 <= AF_LEVEL <= MEMORY_DEPTH
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; 0 <= AE_LEVEL < MEMORY_DEPTH

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of pointers, count and error flags
wr_req  input  1  producer requests a write this cycle
rd_req  input  1  consumer requests a read this cycle
wr_en  output  1  write accepted this cycle; drives the memory write enable
rd_en  output  1  read accepted this cycle
w_addr  output  FIFO_ADDRESS_SIZE  memory write address = w_ptr without its MSB
r_addr  output  FIFO_ADDRESS_SIZE  memory read address = r_ptr without its MSB
w_ptr  output  FIFO_ADDRESS_SIZE+1  write pointer {wrap, addr}
r_ptr  output  FIFO_ADDRESS_SIZE+1  read pointer {wrap, addr}
count  output  FIFO_ADDRESS_SIZE+1  occupancy, 0..MEMORY_DEPTH
full, empty  output  1  occupancy flags
almost_full, almost_empty  output  1  threshold flags
overflow, underflow  output  1  sticky error flags

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at an edge): w_ptr=0, r_ptr=0, count=0, overflow=0, underflow=0. After reset: empty=1, full=0, almost_empty=1, almost_full=0. rst has priority over flush and over requests.
- Flush (flush=1, rst=0): identical state effect to reset. wr_en and rd_en are forced to 0 in that cycle.
- Acceptance (combinational, same cycle):
  - rd_en = rd_req & !empty & !flush & !rst
  - wr_en = wr_req & (!full | rd_en) & !flush & !rst
  - Full + simultaneous read and write: both are accepted (pass-through).
  - Empty + simultaneous read and write: only the write is accepted; there is no read-bypass.
- Pointer advance, per pointer on its accept:
  - if addr == MEMORY_DEPTH-1: addr becomes 0 and the wrap bit toggles
  - otherwise addr increments by 1 and the wrap bit is held
  - Addresses never reach values >= MEMORY_DEPTH.
- Latency: wr_en/rd_en are valid in the request cycle. w_addr/r_addr show the address used by that access. Pointers, count and flags update at the following edge, so flags are registered-state derived.
- Flag derivation:
  - empty = (w_ptr == r_ptr)
  - full = (addresses equal) & (wrap bits differ)
- count is a registered value:
  - +1 on a write alone
  - -1 on a read alone
  - unchanged on both or neither
  - Invariant: count == number of entries, and full == (count == MEMORY_DEPTH).
- almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL). Both are combinational from the registered count.
- Error flags:
  - overflow sets at the edge after any cycle with wr_req=1 and wr_en=0 while flush=0.
  - underflow sets likewise for rd_req=1 and rd_en=0.
  - Both hold until rst or flush.
- Rejected requests leave pointers and count unchanged.
- Reset or flush mid-stream discards contents. Requests in that cycle are neither accepted nor flagged as errors.

Decomposition:
- Shared package fifo_pkg: a clog2 function and localparam ADDR_W derivation helpers, so width/depth legality can be checked at elaboration.
- One sub-module, fifo_wrap_counter: the wrap-bit pointer counter with parameters DEPTH and ADDR_W and ports clk, rst, clr, inc, ptr. It is instantiated twice, once for write and once for read.
- fifo_ptr_ctrl contains the acceptance logic, the count register and the flags.

Test Plan:
Use MEMORY_DEPTH=5, FIFO_ADDRESS_SIZE=3, AF_LEVEL=4, AE_LEVEL=1 unless noted.
1. Reset, then 5 writes -> w_addr sequence 0,1,2,3,4; w_ptr=4'b1000 after the 5th write; count=5, full=1, almost_full=1 from count=4.
2. From full, one read, then writes until full again -> r_addr=0 for the read; w_ptr wraps 4'b1000 -> 4'b1001; full=1 with r_ptr=4'b0001.
3. Full + simultaneous wr_req and rd_req -> wr_en=1, rd_en=1, count stays 5, overflow=0.
4. Empty + simultaneous wr_req and rd_req -> wr_en=1, rd_en=0, count=1, underflow=1 next cycle, almost_empty=1.
5. Write while full, read while empty -> overflow=1 / underflow=1, sticky for 10+ cycles, pointers unchanged; flush -> both flags 0, count=0, empty=1.
6. Mixed random traffic, 20 wraps, FIFO_ADDRESS_SIZE=2 and MEMORY_DEPTH=4 -> count always matches a reference occupancy model; full/empty never both 1; rst asserted mid-burst zeroes everything at the next edge.
